// File: rtl/useq_pkg.sv
// Shared definitions for the microprogram sequencer:
// sequencing-op encodings and the control state enum.
package useq_pkg;

    typedef enum logic [3:0] {
        SEQ_CONT  = 4'd0,
        SEQ_JMP   = 4'd1,
        SEQ_MAP   = 4'd2,
        SEQ_CALL  = 4'd3,
        SEQ_RET   = 4'd4,
        SEQ_WAIT  = 4'd5,
        SEQ_HALT  = 4'd6,
        SEQ_LDCNT = 4'd7,
        SEQ_DJNZ  = 4'd8
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for the microprogram sequencer.
// Push/pop are ignored when full/empty; the caller flags the fault.
module useq_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_sp;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign w_wr_idx = AW'(r_sp);
    assign w_rd_idx = AW'(r_sp - PW'(1));
    assign o_dout   = r_mem[w_rd_idx];
    assign o_full   = (r_sp == PW'(DEPTH));
    assign o_empty  = (r_sp == '0);

    // Stack pointer and storage; reset leaves the stack empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_din;
            r_sp            <= r_sp + PW'(1);
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - PW'(1);
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered micro-address for a combinational ROM.
// Define USEQ_LOOP_EN to add the LDCNT/DJNZ loop counter.
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int IR_W        = 8,
    parameter int UADDR_W     = 8,
    parameter int MAP_SHIFT   = 3,
    parameter int NCOND       = 4,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [IR_W-1:0]          ir,
    input  logic [NCOND-1:0]         cond_in,
    input  logic [3:0]               seq_op,
    input  logic [$clog2(NCOND)-1:0] cond_sel,
    input  logic                     cond_pol,
    input  logic [UADDR_W-1:0]       jump_addr,
    output logic [UADDR_W-1:0]       upc,
    output logic                     busy,
    output logic                     done,
    output logic                     stack_err
);

    localparam int SW = $clog2(NCOND);
    localparam int CW = SW + 1;
    localparam int MW = IR_W + MAP_SHIFT;

    state_e               r_state;
    logic [UADDR_W-1:0]   r_upc;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_sel_ok;
    logic                 w_c;
    logic [UADDR_W-1:0]   w_inc;
    logic [MW-1:0]        w_map_full;
    logic [UADDR_W-1:0]   w_map;
    logic [UADDR_W-1:0]   w_next;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fault;
    logic                 w_halt;
    logic [UADDR_W-1:0]   w_top;
    logic                 w_full;
    logic                 w_empty;

`ifdef USEQ_LOOP_EN
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_dec;
    logic                 w_cnt_ld;
    logic                 w_cnt_dn;
    assign w_cnt_dec = r_cnt - CNT_W'(1);
`endif

    assign w_sel_ok   = ({1'b0, cond_sel} < CW'(NCOND));
    assign w_c        = w_sel_ok ? (cond_in[cond_sel] ^ cond_pol)
                                 : cond_pol;
    assign w_inc      = r_upc + UADDR_W'(1);
    assign w_map_full = {ir, {MAP_SHIFT{1'b0}}};
    assign w_map      = UADDR_W'(w_map_full);

    assign upc        = r_upc;
    assign busy       = r_busy;
    assign done       = r_done;
    assign stack_err  = r_err;

    useq_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (UADDR_W)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_inc),
        .o_dout  (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Decode the current microword into the next micro-address.
    always_comb begin
        w_next  = r_upc;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_fault = 1'b0;
        w_halt  = 1'b0;
`ifdef USEQ_LOOP_EN
        w_cnt_ld = 1'b0;
        w_cnt_dn = 1'b0;
`endif
        if (r_state == ST_RUN) begin
            case (seq_op)
                SEQ_JMP:  w_next = w_c ? jump_addr : w_inc;
                SEQ_MAP:  w_next = w_map;
                SEQ_CALL: begin
                    if (!w_c) begin
                        w_next = w_inc;
                    end else if (w_full) begin
                        w_fault = 1'b1;
                    end else begin
                        w_push = 1'b1;
                        w_next = jump_addr;
                    end
                end
                SEQ_RET: begin
                    if (w_empty) begin
                        w_fault = 1'b1;
                    end else begin
                        w_pop  = 1'b1;
                        w_next = w_top;
                    end
                end
                SEQ_WAIT: w_next = w_c ? w_inc : r_upc;
                SEQ_HALT: begin
                    w_next = '0;
                    w_halt = 1'b1;
                end
`ifdef USEQ_LOOP_EN
                SEQ_LDCNT: begin
                    w_cnt_ld = 1'b1;
                    w_next   = w_inc;
                end
                SEQ_DJNZ: begin
                    w_next = w_inc;
                    if (r_cnt != '0) begin
                        w_cnt_dn = 1'b1;
                        if (w_cnt_dec != '0) begin
                            w_next = jump_addr;
                        end
                    end
                end
`endif
                default:  w_next = w_inc;
            endcase
        end
    end

    // Control FSM with registered upc, busy, done and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_upc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef USEQ_LOOP_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_done <= w_halt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_upc   <= '0;
                    end
                end
                ST_RUN: begin
                    r_upc <= w_next;
                    if (w_fault) begin
                        r_state <= ST_ERR;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (w_halt) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
`ifdef USEQ_LOOP_EN
                    if (w_cnt_ld) begin
                        r_cnt <= CNT_W'(jump_addr);
                    end else if (w_cnt_dn) begin
                        r_cnt <= w_cnt_dec;
                    end
`endif
                end
                default: begin
                    r_state <= ST_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer; the bench plays the microcode ROM.
// Loop-counter expectations follow USEQ_LOOP_EN.
module tb_micro_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] ir;
    logic [3:0] cond_in;
    logic [3:0] seq_op;
    logic [1:0] cond_sel;
    logic       cond_pol;
    logic [7:0] jump_addr;
    logic [7:0] upc;
    logic       busy;
    logic       done;
    logic       stack_err;

    int total = 0;
    int bad   = 0;
    int body;

    micro_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .ir        (ir),
        .cond_in   (cond_in),
        .seq_op    (seq_op),
        .cond_sel  (cond_sel),
        .cond_pol  (cond_pol),
        .jump_addr (jump_addr),
        .upc       (upc),
        .busy      (busy),
        .done      (done),
        .stack_err (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic w(input logic [3:0] op, input logic [1:0] sel,
                     input logic pol, input logic [7:0] addr);
        seq_op    = op;
        cond_sel  = sel;
        cond_pol  = pol;
        jump_addr = addr;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic go();
        start = 1'b1;
        w(4'd0, 2'd0, 1'b0, 8'h00);
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        ir      = 8'h00;
        cond_in = 4'b0000;
        w(4'd0, 2'd0, 1'b0, 8'h00);
        tick();
        tick();
        chk("rst_upc", 32'(upc), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(stack_err), 32'h0);
        reset_n = 1'b1;

        // async reset mid-run with one return address stacked
        go();
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_upc0", 32'(upc), 32'h0);
        tick();
        tick();
        tick();
        chk("t1_upc3", 32'(upc), 32'h3);
        w(4'd3, 2'd0, 1'b1, 8'h05);
        tick();
        chk("t1_upc5", 32'(upc), 32'h5);
        #2 reset_n = 1'b0;
        #1;
        chk("t1_async_upc", 32'(upc), 32'h0);
        chk("t1_async_busy", 32'(busy), 32'h0);
        #2 reset_n = 1'b1;
        go();
        w(4'd4, 2'd0, 1'b0, 8'h00);
        tick();
        chk("t1_ret_empty_err", 32'(stack_err), 32'h1);
        chk("t1_ret_empty_busy", 32'(busy), 32'h0);
        chk("t1_ret_empty_upc", 32'(upc), 32'h0);
        pulse_reset();
        chk("t1_err_clr", 32'(stack_err), 32'h0);

        // map, jumps, wait, wrap, halt
        go();
        tick();
        chk("t2_upc1", 32'(upc), 32'h1);
        ir = 8'h02;
        w(4'd2, 2'd0, 1'b0, 8'h00);
        tick();
        chk("t2_map02", 32'(upc), 32'h10);
        ir = 8'h3F;
        tick();
        chk("t2_map3f", 32'(upc), 32'hF8);
        cond_in = 4'b0010;
        w(4'd1, 2'd1, 1'b0, 8'h40);
        tick();
        chk("t3_jmp_taken", 32'(upc), 32'h40);
        w(4'd1, 2'd1, 1'b1, 8'h60);
        tick();
        chk("t3_jmp_not", 32'(upc), 32'h41);
        w(4'd5, 2'd2, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_wait_hold", 32'(upc), 32'h41);
        end
        cond_in = 4'b0100;
        tick();
        chk("t3_wait_go", 32'(upc), 32'h42);
        w(4'd1, 2'd3, 1'b1, 8'h7E);
        tick();
        chk("t3_jmp_sel3", 32'(upc), 32'h7E);
        w(4'd1, 2'd0, 1'b1, 8'hFF);
        tick();
        chk("t3_jmp_ff", 32'(upc), 32'hFF);
        w(4'd0, 2'd0, 1'b0, 8'h00);
        tick();
        chk("t3_wrap", 32'(upc), 32'h00);
        chk("t3_wrap_busy", 32'(busy), 32'h1);
        w(4'd6, 2'd0, 1'b0, 8'h00);
        tick();
        chk("t3_halt_done", 32'(done), 32'h1);
        w(4'd1, 2'd0, 1'b1, 8'h33);
        tick();
        chk("t3_idle_hold", 32'(upc), 32'h0);
        chk("t3_idle_done", 32'(done), 32'h0);

        // nested calls, returns, overflow
        cond_in = 4'b0000;
        go();
        w(4'd3, 2'd0, 1'b1, 8'h10);
        tick();
        chk("t4_call1", 32'(upc), 32'h10);
        w(4'd3, 2'd0, 1'b1, 8'h20);
        tick();
        chk("t4_call2", 32'(upc), 32'h20);
        w(4'd3, 2'd0, 1'b1, 8'h30);
        tick();
        chk("t4_call3", 32'(upc), 32'h30);
        w(4'd3, 2'd0, 1'b1, 8'h50);
        tick();
        chk("t4_call4", 32'(upc), 32'h50);
        w(4'd4, 2'd0, 1'b0, 8'h00);
        tick();
        chk("t4_ret4", 32'(upc), 32'h31);
        tick();
        chk("t4_ret3", 32'(upc), 32'h21);
        tick();
        chk("t4_ret2", 32'(upc), 32'h11);
        tick();
        chk("t4_ret1", 32'(upc), 32'h01);
        w(4'd3, 2'd0, 1'b1, 8'h10);
        tick();
        w(4'd3, 2'd0, 1'b1, 8'h20);
        tick();
        w(4'd3, 2'd0, 1'b1, 8'h30);
        tick();
        w(4'd3, 2'd0, 1'b1, 8'h50);
        tick();
        chk("t4_refill", 32'(upc), 32'h50);
        w(4'd3, 2'd0, 1'b0, 8'h60);
        tick();
        chk("t4_call_c0_full", 32'(upc), 32'h51);
        chk("t4_call_c0_err", 32'(stack_err), 32'h0);
        w(4'd3, 2'd0, 1'b1, 8'h60);
        tick();
        chk("t4_ovf_err", 32'(stack_err), 32'h1);
        chk("t4_ovf_busy", 32'(busy), 32'h0);
        chk("t4_ovf_upc", 32'(upc), 32'h51);
        go();
        chk("t4_err_start_busy", 32'(busy), 32'h0);
        chk("t4_err_start_upc", 32'(upc), 32'h51);
        chk("t4_err_done", 32'(done), 32'h0);
        pulse_reset();

        // halt at 0x20
        go();
        w(4'd1, 2'd0, 1'b1, 8'h20);
        tick();
        chk("t5_upc20", 32'(upc), 32'h20);
        w(4'd6, 2'd0, 1'b0, 8'h00);
        tick();
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_upc0", 32'(upc), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        w(4'd0, 2'd0, 1'b0, 8'h00);
        tick();
        chk("t5_done_1cyc", 32'(done), 32'h0);

        // loop counter
        go();
        w(4'd7, 2'd0, 1'b0, 8'h03);
        tick();
        chk("t6_ldcnt", 32'(upc), 32'h1);
        body = 0;
        for (int i = 0; i < 20 && upc != 8'h03; i++) begin
            if (upc == 8'h01) begin
                body++;
                w(4'd0, 2'd0, 1'b0, 8'h00);
            end else begin
                w(4'd8, 2'd0, 1'b0, 8'h01);
            end
            tick();
        end
        chk("t6_exit", 32'(upc), 32'h3);
`ifdef USEQ_LOOP_EN
        chk("t6_body", 32'(body), 32'd3);
`else
        chk("t6_body", 32'(body), 32'd1);
`endif
        w(4'd7, 2'd0, 1'b0, 8'h00);
        tick();
        w(4'd8, 2'd0, 1'b0, 8'h70);
        tick();
        chk("t6_djnz_zero", 32'(upc), 32'h5);
        w(4'd7, 2'd0, 1'b0, 8'h01);
        tick();
        w(4'd8, 2'd0, 1'b0, 8'h70);
        tick();
        chk("t6_djnz_one", 32'(upc), 32'h7);
        w(4'd9, 2'd0, 1'b0, 8'h70);
        tick();
        chk("t6_op9", 32'(upc), 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
